pipelined_register_file: RTL and testbench
==========================================

PIPELINED_REGISTER_FILE -- requirements
Module: pipelined_register_file

Interface
REQ-001 SHALL have parameter XLEN, default 32, data width in bits.
REQ-002 SHALL have parameter NREGS, default 32, register count; power of two, at least 2.
REQ-003 SHALL have parameter NREAD, default 2, number of read ports, 1..4.
REQ-004 SHALL derive localparam AW = $clog2(NREGS), the address width.
REQ-005 SHALL have port clock, input, 1, rising-edge clock.
REQ-006 SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-007 SHALL have port ready, output, 1, high when the clear sequence is done and the block accepts operations.
REQ-008 SHALL have port rd_addr, input, NREAD*AW, read addresses; port k occupies bits [k*AW +: AW].
REQ-009 SHALL have port rd_data, output, NREAD*XLEN, read data; port k occupies bits [k*XLEN +: XLEN].
REQ-010 SHALL have port rd_busy, output, NREAD, scoreboard busy flag per read port.
REQ-011 SHALL have port wr_en, input, 1, writeback strobe.
REQ-012 SHALL have ports wr_addr (input, AW) and wr_data (input, XLEN), the writeback target and value.
REQ-013 SHALL have port issue_en, input, 1, marks a destination pending.
REQ-014 SHALL have port issue_addr, input, AW, the destination being issued.

Function
REQ-015 SHALL implement a two-state FSM, CLEAR and RUN; reset forces CLEAR with clear counter = 1.
REQ-016 In CLEAR, SHALL zero register[counter] and busy[counter] each cycle, counter incrementing; on the edge where counter == NREGS-1 is cleared, SHALL go to RUN. Clear takes NREGS-1 cycles.
REQ-017 ready SHALL be 0 in CLEAR and 1 in RUN; in CLEAR, wr_en and issue_en are ignored, rd_data is all zeros and rd_busy is all zeros.
REQ-018 Reads SHALL be combinational, with rd_data[k] = register[rd_addr[k]].
REQ-019 Address 0 SHALL always read 0 and never be busy; writes and issues to address 0 are ignored.
REQ-020 In RUN, wr_en with wr_addr != 0 SHALL write wr_data at the rising edge and clear busy[wr_addr].
REQ-021 In RUN, issue_en with issue_addr != 0 SHALL set busy[issue_addr] at the rising edge.
REQ-022 Issue and writeback to the same address in the same cycle SHALL leave busy set (issue wins), with the data still written.
REQ-023 rd_busy[k] SHALL equal busy[rd_addr[k]], subject to REQ-027.
REQ-024 Multiple read ports addressing the same register SHALL return identical values.
REQ-025 Writeback to a non-busy register SHALL be legal and SHALL leave busy clear.

Reset
REQ-026 Reset asserted at any time, including mid-CLEAR or mid-RUN, SHALL restart CLEAR at counter 1 on the next edge with ready = 0; no other output depends on reset polarity beyond REQ-017.

Configuration
REQ-027 With REGFILE_BYPASS_EN defined, a RUN-state write with wr_en = 1 and wr_addr == rd_addr[k] != 0 SHALL forward wr_data to rd_data[k] in the same cycle; rd_busy[k] then reads 0 unless issue_en targets the same address in that cycle. Without the macro, reads SHALL reflect only the stored state, and the write becomes visible the cycle after.

Structure
REQ-028 Package regfile_pkg SHALL hold the FSM state enum (CLEAR, RUN) and the default XLEN/NREGS/NREAD constants.
REQ-029 SHALL instantiate one sub-module, regfile_scoreboard, which owns the busy bit vector, its set/clear/clear-sequence logic and the busy lookups.

Verification
REQ-030 Clear: assert reset for 1 cycle -> ready = 0 for exactly 31 cycles (NREGS = 32), then 1; reads of x1..x31 return 0.
REQ-031 Write/read: wr x5 = 0xDEADBEEF; next cycle rd_addr0 = 5, rd_addr1 = 5 -> both rd_data = 0xDEADBEEF; wr x0 = 0x1234 -> x0 reads 0.
REQ-032 Scoreboard: issue x7 -> next cycle rd_busy = 1 for x7; wr x7 = 0x55 -> next cycle busy = 0 and data = 0x55; issue + wr x7 same cycle -> busy stays 1.
REQ-033 Bypass: wr x3 = 0xA5A5A5A5 while rd_addr0 = 3 in the same cycle -> with macro, rd_data0 = 0xA5A5A5A5 that cycle; without, old value that cycle and new value next.
REQ-034 Reset mid-operation: fill x1..x4, issue x2, assert reset at clear counter 10 and again in RUN -> CLEAR restarts, all data and busy bits read 0 after ready rises.
REQ-035 Parameter sweep: NREGS = 16, NREAD = 3, XLEN = 64 -> clear takes 15 cycles; all three ports read independent addresses correctly.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types and default sizing for the pipelined register file.
package regfile_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    localparam int DEF_XLEN  = 32;
    localparam int DEF_NREGS = 32;
    localparam int DEF_NREAD = 2;

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard: one pending flag per register, set on issue,
// cleared on writeback, wiped by the clear sequence.
// Optional REGFILE_BYPASS_EN: busy lookup sees a same-cycle writeback.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int NREGS = DEF_NREGS,
    parameter int NREAD = DEF_NREAD,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  i_run,
    input  logic [AW-1:0]         i_clear_idx,
    input  logic                  i_set_en,
    input  logic [AW-1:0]         i_set_addr,
    input  logic                  i_clr_en,
    input  logic [AW-1:0]         i_clr_addr,
    input  logic [NREAD*AW-1:0]   i_rd_addr,
    output logic [NREAD-1:0]      o_rd_busy
);

    logic [NREGS-1:0] r_busy;

    // Busy vector update; set follows clear so a same-cycle issue wins
    always_ff @(posedge clock) begin
        if (reset) begin
            r_busy <= '0;
        end else if (!i_run) begin
            r_busy[i_clear_idx] <= 1'b0;
        end else begin
            if (i_clr_en && i_clr_addr != '0) begin
                r_busy[i_clr_addr] <= 1'b0;
            end
            if (i_set_en && i_set_addr != '0) begin
                r_busy[i_set_addr] <= 1'b1;
            end
        end
    end

    // Per-port busy lookup; x0 and the clear phase always report not busy
    always_comb begin
        o_rd_busy = '0;
        for (int unsigned k = 0; k < NREAD; k++) begin
            if (i_run && i_rd_addr[k*AW +: AW] != '0) begin
`ifdef REGFILE_BYPASS_EN
                if (i_clr_en && i_clr_addr == i_rd_addr[k*AW +: AW]) begin
                    o_rd_busy[k] = i_set_en && (i_set_addr == i_rd_addr[k*AW +: AW]);
                end else begin
                    o_rd_busy[k] = r_busy[i_rd_addr[k*AW +: AW]];
                end
`else
                o_rd_busy[k] = r_busy[i_rd_addr[k*AW +: AW]];
`endif
            end
        end
    end

endmodule

// File: rtl/pipelined_register_file.sv
// Multi-read-port register file with pending-destination scoreboard and
// a post-reset clear sequence that zeroes one register per cycle.
// Optional REGFILE_BYPASS_EN: same-cycle writeback forwarding to reads.
module pipelined_register_file
    import regfile_pkg::*;
#(
    parameter  int XLEN  = DEF_XLEN,
    parameter  int NREGS = DEF_NREGS,
    parameter  int NREAD = DEF_NREAD,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic                    clock,
    input  logic                    reset,
    output logic                    ready,
    input  logic [NREAD*AW-1:0]     rd_addr,
    output logic [NREAD*XLEN-1:0]   rd_data,
    output logic [NREAD-1:0]        rd_busy,
    input  logic                    wr_en,
    input  logic [AW-1:0]           wr_addr,
    input  logic [XLEN-1:0]         wr_data,
    input  logic                    issue_en,
    input  logic [AW-1:0]           issue_addr
);

    state_t          r_state;
    state_t          w_next_state;
    logic [AW-1:0]   r_clr_cnt;
    logic [XLEN-1:0] r_regs [NREGS];
    logic            w_run;
    logic            w_wr_ok;

    assign w_wr_ok = wr_en && (wr_addr != '0);

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= CLEAR;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state: leave CLEAR once the last register is being zeroed
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            CLEAR:   if (r_clr_cnt == AW'(NREGS - 1)) w_next_state = RUN;
            RUN:     w_next_state = RUN;
            default: w_next_state = CLEAR;
        endcase
    end

    // FSM outputs
    always_comb begin
        w_run = (r_state == RUN);
        ready = w_run;
    end

    // Clear counter; x0 is hardwired so the sweep starts at 1
    always_ff @(posedge clock) begin
        if (reset) begin
            r_clr_cnt <= AW'(1);
        end else if (r_state == CLEAR) begin
            r_clr_cnt <= r_clr_cnt + AW'(1);
        end
    end

    // Register storage: clear sweep in CLEAR, writeback in RUN
    always_ff @(posedge clock) begin
        if (!reset) begin
            if (r_state == CLEAR) begin
                r_regs[r_clr_cnt] <= '0;
            end else if (w_wr_ok) begin
                r_regs[wr_addr] <= wr_data;
            end
        end
    end

    // Combinational read ports; x0 and the clear phase read zero
    always_comb begin
        rd_data = '0;
        for (int unsigned k = 0; k < NREAD; k++) begin
            if (w_run && rd_addr[k*AW +: AW] != '0) begin
`ifdef REGFILE_BYPASS_EN
                if (w_wr_ok && wr_addr == rd_addr[k*AW +: AW]) begin
                    rd_data[k*XLEN +: XLEN] = wr_data;
                end else begin
                    rd_data[k*XLEN +: XLEN] = r_regs[rd_addr[k*AW +: AW]];
                end
`else
                rd_data[k*XLEN +: XLEN] = r_regs[rd_addr[k*AW +: AW]];
`endif
            end
        end
    end

    regfile_scoreboard #(
        .NREGS (NREGS),
        .NREAD (NREAD),
        .AW    (AW)
    ) u_scoreboard (
        .clock       (clock),
        .reset       (reset),
        .i_run       (w_run),
        .i_clear_idx (r_clr_cnt),
        .i_set_en    (issue_en),
        .i_set_addr  (issue_addr),
        .i_clr_en    (wr_en),
        .i_clr_addr  (wr_addr),
        .i_rd_addr   (rd_addr),
        .o_rd_busy   (rd_busy)
    );

endmodule

// File: tb/tb_pipelined_register_file.sv
// Self-checking bench for pipelined_register_file: default instance plus
// a 16x64, 3-read-port instance; honours REGFILE_BYPASS_EN if defined.
module tb_pipelined_register_file;

    localparam int XL  = 32;
    localparam int NR  = 32;
    localparam int NP  = 2;
    localparam int AWA = 5;
    localparam int XB  = 64;
    localparam int NB  = 16;
    localparam int PB  = 3;
    localparam int AB  = 4;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    // Instance A (defaults)
    logic              reset;
    logic              ready;
    logic [NP*AWA-1:0] rd_addr;
    logic [NP*XL-1:0]  rd_data;
    logic [NP-1:0]     rd_busy;
    logic              wr_en;
    logic [AWA-1:0]    wr_addr;
    logic [XL-1:0]     wr_data;
    logic              issue_en;
    logic [AWA-1:0]    issue_addr;

    // Instance B (parameter sweep)
    logic              b_reset;
    logic              b_ready;
    logic [PB*AB-1:0]  b_rd_addr;
    logic [PB*XB-1:0]  b_rd_data;
    logic [PB-1:0]     b_rd_busy;
    logic              b_wr_en;
    logic [AB-1:0]     b_wr_addr;
    logic [XB-1:0]     b_wr_data;
    logic              b_issue_en;
    logic [AB-1:0]     b_issue_addr;

    pipelined_register_file #(.XLEN(XL), .NREGS(NR), .NREAD(NP)) dut_a (
        .clock(clock), .reset(reset), .ready(ready),
        .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .issue_en(issue_en), .issue_addr(issue_addr)
    );

    pipelined_register_file #(.XLEN(XB), .NREGS(NB), .NREAD(PB)) dut_b (
        .clock(clock), .reset(b_reset), .ready(b_ready),
        .rd_addr(b_rd_addr), .rd_data(b_rd_data), .rd_busy(b_rd_busy),
        .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
        .issue_en(b_issue_en), .issue_addr(b_issue_addr)
    );

    // Reference model for instance A: architectural register contents,
    // pending flags, and the number of clear cycles still to run.
    logic [XL-1:0] m_mem  [NR];
    logic          m_busy [NR];
    int            m_clear_left = -1;
    logic [XB-1:0] bm     [NB];

    int errors = 0;
    int checks = 0;

    function automatic logic [XL-1:0] exp_data(input logic [AWA-1:0] a);
        if (m_clear_left != 0 || a == '0) return '0;
`ifdef REGFILE_BYPASS_EN
        if (wr_en && wr_addr == a) return wr_data;
`endif
        return m_mem[a];
    endfunction

    function automatic logic exp_busy(input logic [AWA-1:0] a);
        if (m_clear_left != 0 || a == '0) return 1'b0;
`ifdef REGFILE_BYPASS_EN
        if (wr_en && wr_addr == a) return issue_en && (issue_addr == a);
`endif
        return m_busy[a];
    endfunction

    // Advance one clock, updating the model from the inputs seen at the edge
    task automatic cycle();
        @(posedge clock);
        if (reset) begin
            m_clear_left = NR - 1;
            for (int i = 0; i < NR; i++) begin
                m_mem[i]  = '0;
                m_busy[i] = 1'b0;
            end
        end else if (m_clear_left > 0) begin
            m_clear_left--;
        end else if (m_clear_left == 0) begin
            if (wr_en && wr_addr != '0) begin
                m_mem[wr_addr]  = wr_data;
                m_busy[wr_addr] = 1'b0;
            end
            if (issue_en && issue_addr != '0) m_busy[issue_addr] = 1'b1;
        end
        @(negedge clock);
    endtask

    task automatic idle_a();
        wr_en = 1'b0; issue_en = 1'b0;
        wr_addr = '0; wr_data = '0; issue_addr = '0;
    endtask

    task automatic test_reset();
        int n;
        idle_a();
        rd_addr = '0;
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        n = 0;
        while (!ready && n < 100) begin
            wr_en      = 1'($urandom_range(0, 1));
            wr_addr    = AWA'($urandom_range(1, NR - 1));
            wr_data    = $urandom;
            issue_en   = 1'($urandom_range(0, 1));
            issue_addr = AWA'($urandom_range(1, NR - 1));
            for (int k = 0; k < NP; k++) rd_addr[k*AWA +: AWA] = AWA'($urandom_range(0, NR - 1));
            #1;
            checks++;
            if (rd_data !== '0 || rd_busy !== '0) begin
                errors++;
                $display("FAIL clear_outputs: got data=%h busy=%b expected all zero", rd_data, rd_busy);
            end
            cycle();
            n++;
        end
        idle_a();
        checks++;
        if (n != NR - 1) begin
            errors++;
            $display("FAIL clear_len: got %0d cycles expected %0d", n, NR - 1);
        end
        for (int a = 1; a < NR; a += 2) begin
            rd_addr = {AWA'((a + 1) % NR), AWA'(a)};
            #1;
            checks++;
            if (ready !== 1'b1 || rd_data !== '0 || rd_busy !== '0) begin
                errors++;
                $display("FAIL post_clear x%0d: got ready=%b data=%h busy=%b expected 1/0/0", a, ready, rd_data, rd_busy);
            end
            cycle();
        end
    endtask

    task automatic test_write_read();
        rd_addr = {AWA'(5), AWA'(5)};
        wr_en = 1'b1; wr_addr = AWA'(5); wr_data = 32'hDEADBEEF;
        #1;
        for (int k = 0; k < NP; k++) begin
            checks++;
            if (rd_data[k*XL +: XL] !== exp_data(AWA'(5))) begin
                errors++;
                $display("FAIL wr_x5_same_cycle port%0d: got %h expected %h", k, rd_data[k*XL +: XL], exp_data(AWA'(5)));
            end
        end
        cycle();
        idle_a();
        #1;
        checks++;
        if (rd_data !== {32'hDEADBEEF, 32'hDEADBEEF}) begin
            errors++;
            $display("FAIL rd_x5_both_ports: got %h expected %h", rd_data, {32'hDEADBEEF, 32'hDEADBEEF});
        end
        rd_addr = '0;
        wr_en = 1'b1; wr_addr = '0; wr_data = 32'h1234;
        cycle();
        idle_a();
        #1;
        checks++;
        if (rd_data !== '0 || rd_busy !== '0) begin
            errors++;
            $display("FAIL x0_reads_zero: got data=%h busy=%b expected 0/0", rd_data, rd_busy);
        end
    endtask

    task automatic test_scoreboard();
        rd_addr = {AWA'(7), AWA'(7)};
        issue_en = 1'b1; issue_addr = AWA'(7);
        cycle();
        idle_a();
        #1;
        checks++;
        if (rd_busy !== 2'b11) begin
            errors++;
            $display("FAIL issue_x7_busy: got %b expected 11", rd_busy);
        end
        wr_en = 1'b1; wr_addr = AWA'(7); wr_data = 32'h55;
        cycle();
        idle_a();
        #1;
        checks++;
        if (rd_busy !== 2'b00 || rd_data !== {32'h55, 32'h55}) begin
            errors++;
            $display("FAIL wb_x7: got busy=%b data=%h expected 00/%h", rd_busy, rd_data, {32'h55, 32'h55});
        end
        wr_en = 1'b1; wr_addr = AWA'(7); wr_data = 32'h66;
        issue_en = 1'b1; issue_addr = AWA'(7);
        #1;
        checks++;
        if (rd_busy[0] !== exp_busy(AWA'(7))) begin
            errors++;
            $display("FAIL issue_wb_same_cycle_busy: got %b expected %b", rd_busy[0], exp_busy(AWA'(7)));
        end
        cycle();
        idle_a();
        #1;
        checks++;
        if (rd_busy !== 2'b11 || rd_data[XL-1:0] !== 32'h66) begin
            errors++;
            $display("FAIL issue_wins: got busy=%b data=%h expected 11/00000066", rd_busy, rd_data[XL-1:0]);
        end
        rd_addr = {AWA'(0), AWA'(8)};
        wr_en = 1'b1; wr_addr = AWA'(8); wr_data = 32'h8888;
        issue_en = 1'b1; issue_addr = AWA'(0);
        cycle();
        idle_a();
        #1;
        checks++;
        if (rd_busy !== 2'b00 || rd_data !== {32'h0, 32'h8888}) begin
            errors++;
            $display("FAIL wb_nonbusy_x8: got busy=%b data=%h expected 00/%h", rd_busy, rd_data, {32'h0, 32'h8888});
        end
    endtask

    task automatic test_bypass();
        logic [XL-1:0] old;
        logic          exp_b;
        old = m_mem[3];
        rd_addr = {AWA'(0), AWA'(3)};
        wr_en = 1'b1; wr_addr = AWA'(3); wr_data = 32'hA5A5A5A5;
        #1;
        checks++;
`ifdef REGFILE_BYPASS_EN
        if (rd_data[XL-1:0] !== 32'hA5A5A5A5) begin
            errors++;
            $display("FAIL bypass_same_cycle: got %h expected a5a5a5a5", rd_data[XL-1:0]);
        end
`else
        if (rd_data[XL-1:0] !== old) begin
            errors++;
            $display("FAIL no_bypass_same_cycle: got %h expected %h", rd_data[XL-1:0], old);
        end
`endif
        cycle();
        idle_a();
        #1;
        checks++;
        if (rd_data[XL-1:0] !== 32'hA5A5A5A5) begin
            errors++;
            $display("FAIL bypass_next_cycle: got %h expected a5a5a5a5", rd_data[XL-1:0]);
        end
        issue_en = 1'b1; issue_addr = AWA'(9);
        cycle();
        idle_a();
        rd_addr = {AWA'(0), AWA'(9)};
        wr_en = 1'b1; wr_addr = AWA'(9); wr_data = 32'h9;
`ifdef REGFILE_BYPASS_EN
        exp_b = 1'b0;
`else
        exp_b = 1'b1;
`endif
        #1;
        checks++;
        if (rd_busy[0] !== exp_b) begin
            errors++;
            $display("FAIL bypass_busy_x9: got %b expected %b", rd_busy[0], exp_b);
        end
        cycle();
        idle_a();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            wr_en      = 1'($urandom_range(0, 1));
            wr_addr    = AWA'($urandom_range(0, 7));
            wr_data    = $urandom;
            issue_en   = 1'($urandom_range(0, 1));
            issue_addr = AWA'($urandom_range(0, 7));
            for (int k = 0; k < NP; k++) rd_addr[k*AWA +: AWA] = AWA'($urandom_range(0, 7));
            #1;
            for (int k = 0; k < NP; k++) begin
                checks++;
                if (rd_data[k*XL +: XL] !== exp_data(rd_addr[k*AWA +: AWA]) ||
                    rd_busy[k] !== exp_busy(rd_addr[k*AWA +: AWA])) begin
                    errors++;
                    $display("FAIL random c%0d port%0d x%0d: got data=%h busy=%b expected %h/%b", c, k,
                             rd_addr[k*AWA +: AWA], rd_data[k*XL +: XL], rd_busy[k],
                             exp_data(rd_addr[k*AWA +: AWA]), exp_busy(rd_addr[k*AWA +: AWA]));
                end
            end
            cycle();
        end
        idle_a();
    endtask

    task automatic test_reset_mid();
        int n;
        for (int rep = 0; rep < 2; rep++) begin
            for (int a = 1; a <= 4; a++) begin
                wr_en = 1'b1; wr_addr = AWA'(a); wr_data = $urandom | 32'h1;
                cycle();
            end
            idle_a();
            issue_en = 1'b1; issue_addr = AWA'(2);
            cycle();
            idle_a();
            reset = 1'b1;
            cycle();
            reset = 1'b0;
            if (rep == 0) begin
                repeat (9) cycle();
                checks++;
                if (ready !== 1'b0) begin
                    errors++;
                    $display("FAIL mid_clear_ready: got %b expected 0", ready);
                end
                reset = 1'b1;
                cycle();
                reset = 1'b0;
            end
            n = 0;
            while (!ready && n < 100) begin
                cycle();
                n++;
            end
            checks++;
            if (n != NR - 1) begin
                errors++;
                $display("FAIL reset_mid rep%0d clear_len: got %0d expected %0d", rep, n, NR - 1);
            end
            for (int a = 1; a <= 4; a++) begin
                rd_addr = {AWA'(a), AWA'(a)};
                #1;
                checks++;
                if (rd_data !== '0 || rd_busy !== '0) begin
                    errors++;
                    $display("FAIL reset_mid rep%0d x%0d: got data=%h busy=%b expected 0/0", rep, a, rd_data, rd_busy);
                end
                cycle();
            end
        end
    endtask

    task automatic test_param_sweep();
        int n;
        logic [AB-1:0] a;
        b_wr_en = 1'b0; b_issue_en = 1'b0; b_wr_addr = '0; b_issue_addr = '0;
        b_wr_data = '0; b_rd_addr = '0;
        b_reset = 1'b1;
        cycle();
        b_reset = 1'b0;
        n = 0;
        while (!b_ready && n < 100) begin
            cycle();
            n++;
        end
        checks++;
        if (n != NB - 1) begin
            errors++;
            $display("FAIL sweep_clear_len: got %0d expected %0d", n, NB - 1);
        end
        bm[0] = '0;
        for (int i = 1; i < NB; i++) begin
            b_wr_en = 1'b1; b_wr_addr = AB'(i);
            b_wr_data = {$urandom, $urandom};
            bm[i] = b_wr_data;
            cycle();
        end
        b_wr_en = 1'b0;
        for (int c = 0; c < 24; c++) begin
            for (int k = 0; k < PB; k++) b_rd_addr[k*AB +: AB] = AB'($urandom_range(0, NB - 1));
            #1;
            for (int k = 0; k < PB; k++) begin
                a = b_rd_addr[k*AB +: AB];
                checks++;
                if (b_rd_data[k*XB +: XB] !== bm[a] || b_rd_busy[k] !== 1'b0) begin
                    errors++;
                    $display("FAIL sweep_read c%0d port%0d x%0d: got %h/%b expected %h/0", c, k, a,
                             b_rd_data[k*XB +: XB], b_rd_busy[k], bm[a]);
                end
            end
            cycle();
        end
        b_issue_en = 1'b1; b_issue_addr = AB'(9);
        cycle();
        b_issue_en = 1'b0;
        b_rd_addr = {AB'(9), AB'(5), AB'(0)};
        #1;
        checks++;
        if (b_rd_busy !== 3'b100 || b_rd_data[2*XB +: XB] !== bm[9]) begin
            errors++;
            $display("FAIL sweep_busy_x9: got busy=%b data=%h expected 100/%h", b_rd_busy, b_rd_data[2*XB +: XB], bm[9]);
        end
    endtask

    initial begin
        reset = 1'b0;
        b_reset = 1'b1;
        b_wr_en = 1'b0; b_issue_en = 1'b0; b_wr_addr = '0; b_issue_addr = '0;
        b_wr_data = '0; b_rd_addr = '0;
        idle_a();
        rd_addr = '0;
        @(negedge clock);
        test_reset();
        test_write_read();
        test_scoreboard();
        test_bypass();
        test_random();
        test_reset_mid();
        test_param_sweep();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog expired");
    end

endmodule
